// File: rtl/blink_pkg.sv
// Shared types and default timing for the blink frame receiver.
// Defaults describe a 1 s on / 2 s off frame at 27 MHz.
package blink_pkg;

  localparam int CLK_HZ   = 27000000;
  localparam int HIGH_CYC = 27000000;
  localparam int LOW_CYC  = 54000000;
  localparam int TOL_CYC  = 270000;
  localparam int CNT_W    = 27;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HIGH,
    LOW
  } state_e;

endpackage

// File: rtl/blink_rx_sig_sync.sv
// Two-flop synchronizer plus registered edge detect.
// s, rise and fall leave the same register stage, so they stay aligned.
module sig_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic s_q, s_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // next values: shift the line in, compare synced level to last one
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
    s_d    = sync_q;
    rise_d = sync_q & ~s_q;
    fall_d = ~sync_q & s_q;
  end

  // line flops preset high so a high line at release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      s_q    <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      s_q    <= s_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/blink_rx.sv
// Blink frame receiver: measures high/low phase lengths and
// flags frames that fall inside the tolerance window.
module blink_rx
  import blink_pkg::*;
#(
  parameter int HIGH_CYC = blink_pkg::HIGH_CYC,
  parameter int LOW_CYC  = blink_pkg::LOW_CYC,
  parameter int TOL_CYC  = blink_pkg::TOL_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             locked,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt
);

  localparam logic [CNT_W-1:0] H_MIN = CNT_W'(HIGH_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(HIGH_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] L_MIN = CNT_W'(LOW_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(LOW_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic s, rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcap_q, hcap_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             lock_q, lock_d;

  sig_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (sig_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // frame FSM: count each phase, decide on the closing edge or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcap_d  = hcap_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ARM: begin
        if (!s) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          if (cnt_q < H_MIN) begin
            err_d   = 1'b1;
            state_d = ARM;
          end else begin
            hcap_d  = cnt_q;
            cnt_d   = ONE;
            state_d = LOW;
          end
        end else if (s) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == H_MAX) begin
            err_d   = 1'b1;
            state_d = ARM;
          end
        end
      end
      LOW: begin
        if (rise) begin
          if (cnt_q >= L_MIN && cnt_q <= L_MAX) begin
            ok_d = 1'b1;
            hi_d = hcap_q;
            lo_d = cnt_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = HIGH;
          cnt_d   = ONE;
        end else if (!s) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == L_MAX) begin
            err_d   = 1'b1;
            state_d = ARM;
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  // lock follows the pulses: set by ok, dropped by err
  always_comb begin
    lock_d = lock_q;
    if (ok_d) lock_d = 1'b1;
    else if (err_d) lock_d = 1'b0;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARM;
      cnt_q   <= '0;
      hcap_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hcap_q  <= hcap_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
    end
  end

  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign locked    = lock_q;
  assign high_cnt  = hi_q;
  assign low_cnt   = lo_q;

endmodule

// File: tb/tb_blink_rx.sv
// Directed and randomized frame checks for blink_rx
// with short phase lengths (10/20, tolerance 2).
module tb_blink_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        frame_ok, frame_err, locked;
  logic [26:0] high_cnt, low_cnt;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int ok_n = 0, err_n = 0;
  int last_ok = -1, last_err = -1;
  bit both = 1'b0;
  int t;

  blink_rx #(
    .HIGH_CYC (10),
    .LOW_CYC  (20),
    .TOL_CYC  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .locked    (locked),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_ok) begin
      ok_n++;
      last_ok = cyc;
    end
    if (frame_err) begin
      err_n++;
      last_err = cyc;
    end
    if (frame_ok && frame_err) both = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ok_n = 0;
    err_n = 0;
    last_ok = -1;
    last_err = -1;
  endtask

  task automatic do_reset(input bit v);
    sig_in = v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // 0 = frame accepted, 1 = rejected, from the phase rules
  function automatic int predict(input int h, input int l);
    if (h >= 13) return 1;
    if (h < 8) return 1;
    if (l >= 23) return 1;
    if (l < 18) return 1;
    return 0;
  endfunction

  initial begin
    int h, l, e;

    // reset state
    do_reset(1'b0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_lock", locked, 0);
    check("rst_hc", high_cnt, 0);
    check("rst_lc", low_cnt, 0);

    // nominal 10/20 frame
    hold(0, 6);
    hold(1, 10);
    hold(0, 20);
    clr();
    t = cyc;
    hold(1, 8);
    check("nom_ok_n", ok_n, 1);
    check("nom_err_n", err_n, 0);
    check("nom_lat", last_ok - t, 4);
    check("nom_hc", high_cnt, 10);
    check("nom_lc", low_cnt, 20);
    check("nom_lock", locked, 1);

    // second frame 10/19, then short high of 7
    hold(1, 2);
    hold(0, 19);
    hold(1, 7);
    check("f2_hc", high_cnt, 10);
    check("f2_lc", low_cnt, 19);
    clr();
    t = cyc;
    hold(0, 10);
    check("short_err_n", err_n, 1);
    check("short_ok_n", ok_n, 0);
    check("short_lat", last_err - t, 4);
    check("short_hc", high_cnt, 10);
    check("short_lc", low_cnt, 19);
    check("short_lock", locked, 0);

    // lock, then high stuck for 30
    hold(1, 10);
    hold(0, 20);
    clr();
    t = cyc;
    hold(1, 30);
    check("to_ok_n", ok_n, 1);
    check("to_err_n", err_n, 1);
    check("to_err_lat", last_err - t, 16);
    check("to_lock", locked, 0);
    hold(1, 10);
    check("to_hold_n", ok_n + err_n, 2);
    clr();
    hold(0, 5);
    hold(1, 10);
    hold(0, 20);
    t = cyc;
    hold(1, 8);
    check("to_rec_ok", ok_n, 1);
    check("to_rec_err", err_n, 0);
    check("to_rec_lat", last_ok - t, 4);
    check("to_rec_lock", locked, 1);

    // boundaries: 8/22 accepted, 12/23 rejected
    do_reset(1'b0);
    hold(0, 6);
    hold(1, 8);
    hold(0, 22);
    clr();
    hold(1, 12);
    check("b1_ok_n", ok_n, 1);
    check("b1_hc", high_cnt, 8);
    check("b1_lc", low_cnt, 22);
    check("b1_lock", locked, 1);
    clr();
    t = cyc;
    hold(0, 23);
    hold(1, 6);
    check("b2_err_n", err_n, 1);
    check("b2_ok_n", ok_n, 0);
    check("b2_lat", last_err - t, 26);
    check("b2_hc", high_cnt, 8);
    check("b2_lc", low_cnt, 22);
    check("b2_lock", locked, 0);

    // line high through reset release
    do_reset(1'b1);
    clr();
    hold(1, 20);
    check("hi_rst_n", ok_n + err_n, 0);
    hold(0, 5);
    hold(1, 10);
    hold(0, 20);
    t = cyc;
    hold(1, 8);
    check("hi_rst_ok", ok_n, 1);
    check("hi_rst_lat", last_ok - t, 4);

    // reset in the middle of a low phase
    do_reset(1'b0);
    hold(0, 6);
    hold(1, 10);
    hold(0, 20);
    hold(1, 10);
    hold(0, 10);
    check("mid_pre_lock", locked, 1);
    clr();
    rst = 1'b1;
    #1;
    check("mid_ok", frame_ok, 0);
    check("mid_err", frame_err, 0);
    check("mid_lock", locked, 0);
    check("mid_hc", high_cnt, 0);
    check("mid_lc", low_cnt, 0);
    hold(0, 3);
    rst = 1'b0;
    hold(0, 6);
    check("mid_pulses", ok_n + err_n, 0);
    hold(1, 10);
    hold(0, 20);
    hold(1, 8);
    check("mid_rec_ok", ok_n, 1);
    check("mid_rec_err", err_n, 0);

    // randomized single frames against the phase rules
    for (int i = 0; i < 12; i++) begin
      h = $urandom_range(15, 5);
      l = $urandom_range(25, 15);
      e = predict(h, l);
      do_reset(1'b0);
      hold(0, 6);
      clr();
      hold(1, h);
      hold(0, l);
      hold(1, 10);
      check("rnd_ok_n", ok_n, (e == 0) ? 1 : 0);
      check("rnd_err_n", err_n, (e == 1) ? 1 : 0);
      check("rnd_hc", high_cnt, (e == 0) ? h : 0);
      check("rnd_lc", low_cnt, (e == 0) ? l : 0);
      check("rnd_lock", locked, (e == 0) ? 1 : 0);
    end

    check("never_both", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
